// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/load-store arbiter onto one memory port with 1-cycle read latency; define MEM_ARB_RR_EN for round-robin instead of data priority with starvation override
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;
    state_t state_q, state_d;
`ifdef MEM_ARB_RR_EN
    logic conflict, ptr_q, ptr_d;
    // On conflict the pointer (0 = data) picks the winner, then passes preference to the loser
    always_comb begin
        conflict = !rst && if_req && d_req;
        d_gnt    = !rst && d_req && !(conflict && ptr_q);
        if_gnt   = !rst && if_req && !d_gnt;
        ptr_d    = conflict ? !ptr_q : ptr_q;
    end
    // Round-robin preference pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    localparam int CW = $clog2(STARVE_MAX + 2);
    logic [CW-1:0] starve_q, starve_d;
    logic          force_if;
    // Data wins conflicts until fetch has lost STARVE_MAX cycles in a row
    always_comb begin
        force_if = if_req && starve_q == CW'(STARVE_MAX);
        d_gnt    = !rst && d_req && !force_if;
        if_gnt   = !rst && if_req && !d_gnt;
        starve_d = (!if_req || if_gnt) ? '0 : force_if ? starve_q : starve_q + CW'(1);
    end
    // Consecutive lost-cycle counter for the fetch port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif
    // The response owner next cycle is whoever wins this cycle
    always_comb state_d = if_gnt ? RESP_IF : d_gnt ? RESP_D : IDLE;
    // Response FSM; reset drops any in-flight response at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Memory port steering and zero-gated read data returns
    always_comb begin
        mem_req   = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_be    = d_gnt ? d_be : 4'hF;
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = d_gnt ? d_wdata : '0;
        if_rvalid = state_q == RESP_IF;
        d_rvalid  = state_q == RESP_D;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the maximum consecutive lost cycles for fetch before it is forced to win.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports if_req  input  1, if_addr  input  ADDR_W, if_gnt  output  1, if_rvalid  output  1, if_rdata  output  DATA_W: instruction-fetch requester, read only.
REQ-007 SHALL have ports d_req  input  1, d_we  input  1, d_be  input  4, d_addr  input  ADDR_W, d_wdata  input  DATA_W, d_gnt  output  1, d_rvalid  output  1, d_rdata  output  DATA_W: load/store requester.
REQ-008 SHALL have ports mem_req  output  1, mem_we  output  1, mem_be  output  4, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W: single shared port to memory, with fixed 1-cycle synchronous read latency.

Function
REQ-009 SHALL arbitrate combinationally in cycle N: at most one of if_gnt/d_gnt high, and a gnt is high only when its req is high.
REQ-010 SHALL drive mem_req = if_gnt | d_gnt; mem_addr/mem_we/mem_be/mem_wdata SHALL come from the winner; for a fetch winner, mem_we=0 and mem_be=4'hF.
REQ-011 SHALL default to data-port priority: when both requests are high, d_gnt=1 unless the starvation counter equals STARVE_MAX.
REQ-012 SHALL keep a starvation counter: increment (saturating at STARVE_MAX) when if_req=1 and if_gnt=0; clear when if_gnt=1 or if_req=0.
REQ-013 SHALL grant fetch when the counter equals STARVE_MAX and if_req=1, regardless of d_req.
REQ-014 SHALL keep a response FSM with states IDLE, RESP_IF, RESP_D; the next state is RESP_IF on if_gnt, RESP_D on d_gnt, and IDLE otherwise, re-evaluated every cycle.
REQ-015 SHALL assert if_rvalid exactly in RESP_IF, with if_rdata = mem_rdata.
REQ-016 SHALL assert d_rvalid exactly in RESP_D, for both loads and stores; d_rdata = mem_rdata for loads, don't-care for stores.
REQ-017 SHALL support back-to-back grants every cycle; a new grant SHALL be issued in the same cycle as the previous response (full pipelining, one outstanding access).
REQ-018 SHALL drive if_rdata/d_rdata to 0 when the matching rvalid is low.
REQ-019 SHALL, with neither request high, hold mem_req=0 and mem_we=0, and move the FSM to IDLE next cycle.
REQ-020 SHALL pass requester ADDR_W addresses unmodified, with no alignment checking.

Reset
REQ-021 SHALL, while rst=1, force FSM=IDLE, starvation counter=0, round-robin pointer=data, and if_rvalid=d_rvalid=0 immediately (asynchronous).
REQ-022 SHALL, while rst=1, hold if_gnt=d_gnt=mem_req=mem_we=0.
REQ-023 SHALL drop any in-flight response on reset mid-access; no rvalid follows the reset release.
REQ-024 SHALL allow the first grant in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with MEM_ARB_RR_EN defined, replace REQ-011..REQ-013 with round-robin arbitration: a 1-bit pointer selects the preferred port on conflict; after each conflict the pointer toggles to the loser; the starvation counter is not implemented.
REQ-026 SHALL, without MEM_ARB_RR_EN, use fixed data priority plus the STARVE_MAX starvation override.

Verification
REQ-027 SHALL cover a lone fetch: if_req=1, if_addr=0x8 -> if_gnt=1 and mem_addr=0x8 in cycle N; if_rvalid=1 with if_rdata=mem_rdata in N+1.
REQ-028 SHALL cover a lone store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x4, d_wdata=0xFF04A1C0 -> mem_we=1, mem_be=4'b0011 in N; d_rvalid=1 in N+1.
REQ-029 SHALL cover fixed-priority starvation: if_req=d_req=1 held, STARVE_MAX=4 -> d_gnt for 4 cycles, if_gnt in cycle 5, then the counter clears and d_gnt resumes.
REQ-030 SHALL cover round robin (MEM_ARB_RR_EN): both requests held 6 cycles -> grants alternate D,IF,D,IF,D,IF.
REQ-031 SHALL cover back-to-back traffic: fetch at N, load at N+1 -> if_rvalid at N+1 and d_rvalid at N+2, each with the correct data and no bubble.
REQ-032 SHALL cover reset mid-access: rst asserted in the cycle after d_gnt -> d_rvalid=0 immediately; no rvalid after release; all outputs 0 during reset.
